// File: rtl/sp_usb_pkg.sv
// Shared encodings for the FT245-style USB FIFO bridge.
// State and arbitration types used by the top-level FSM.
package sp_usb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_WRITE = ST_WRITE,
    S_READ  = ST_READ
  } state_e;

  typedef enum logic {
    SRV_READ  = 1'b0,
    SRV_WRITE = 1'b1
  } srv_e;

endpackage

// File: rtl/sp_sync_fifo.sv
// First-word fall-through synchronous FIFO with registered occupancy.
// Push is dropped when full, pop is ignored when empty.
module sp_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sp_usb_fifo_bridge.sv
// FT245-style synchronous USB FIFO bridge with TX/RX buffering.
// One-cycle WRITE/READ strobes, round-robin when both directions are ready.
module sp_usb_fifo_bridge
  import sp_usb_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int TX_DEPTH   = 16,
  parameter  int RX_DEPTH   = 16,
  localparam int TX_CW      = $clog2(TX_DEPTH) + 1,
  localparam int RX_CW      = $clog2(RX_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  inout  wire  [DATA_WIDTH-1:0] usb_data,
  input  logic                  rxf_n,
  input  logic                  txe_n,
  output logic                  rd_n,
  output logic                  wr_n,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  write,
  output logic                  full,
  output logic [DATA_WIDTH-1:0] dout,
  input  logic                  read,
  output logic                  avail,
  output logic [TX_CW-1:0]      tx_count,
  output logic [RX_CW-1:0]      rx_count
);

  state_e state_q, state_d;
  srv_e   last_q, last_d;

  logic [DATA_WIDTH-1:0] tx_head;
  logic                  tx_empty;
  logic                  rx_full;
  logic                  rx_empty;
  logic                  tx_ok;
  logic                  rx_ok;

  sp_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (TX_DEPTH)
  ) u_tx (
    .clk   (clk),
    .rst   (rst),
    .push  (write),
    .din   (din),
    .pop   (state_q == S_WRITE),
    .dout  (tx_head),
    .count (tx_count),
    .full  (full),
    .empty (tx_empty)
  );

  sp_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (RX_DEPTH)
  ) u_rx (
    .clk   (clk),
    .rst   (rst),
    .push  (state_q == S_READ),
    .din   (usb_data),
    .pop   (read),
    .dout  (dout),
    .count (rx_count),
    .full  (rx_full),
    .empty (rx_empty)
  );

  assign avail    = !rx_empty;
  assign tx_ok    = !tx_empty && !txe_n;
  assign rx_ok    = !rx_full && !rxf_n;
  assign rd_n     = (state_q != S_READ);
  assign wr_n     = (state_q != S_WRITE);
  assign usb_data = (state_q == S_WRITE) ? tx_head : 'z;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= SRV_READ;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Ties go to the direction not served last.
  always_comb begin
    state_d = S_IDLE;
    last_d  = last_q;
    if (state_q == S_IDLE) begin
      unique case (1'b1)
        tx_ok && (!rx_ok || last_q == SRV_READ): begin
          state_d = S_WRITE;
          last_d  = SRV_WRITE;
        end
        rx_ok && (!tx_ok || last_q == SRV_WRITE): begin
          state_d = S_READ;
          last_d  = SRV_READ;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sp_usb_fifo_bridge.sv
// Directed bench for sp_usb_fifo_bridge with a queue-based reference
// model checked every cycle, plus literal checks per scenario.
module tb_sp_usb_fifo_bridge;

  logic       clk = 0;
  logic       rst;
  wire  [7:0] usb_data;
  logic       rxf_n, txe_n;
  logic       rd_n, wr_n;
  logic [7:0] din;
  logic       write, read;
  logic       full, avail;
  logic [7:0] dout;
  logic [4:0] tx_count, rx_count;

  logic [7:0] chip_data = 8'hA0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit chk_on = 0;

  logic [7:0] m_tx[$];
  logic [7:0] m_rx[$];
  int         m_ph   = 0;
  int         m_last = 0;

  byte        slog[$];
  logic [7:0] wlog[$];
  int         wcyc[$];

  sp_usb_fifo_bridge dut (
    .clk      (clk),
    .rst      (rst),
    .usb_data (usb_data),
    .rxf_n    (rxf_n),
    .txe_n    (txe_n),
    .rd_n     (rd_n),
    .wr_n     (wr_n),
    .din      (din),
    .write    (write),
    .full     (full),
    .dout     (dout),
    .read     (read),
    .avail    (avail),
    .tx_count (tx_count),
    .rx_count (rx_count)
  );

  assign usb_data = !rd_n ? chip_data : 'z;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_logs();
    slog.delete();
    wlog.delete();
    wcyc.delete();
  endtask

  function automatic int cnt(input byte c);
    int k = 0;
    foreach (slog[i]) if (slog[i] == c) k++;
    return k;
  endfunction

  // Reference model: phase 0 idle, 1 write, 2 read.
  always @(posedge clk) begin
    int  txn, rxn;
    bit  tx_ok, rx_ok;
    cyc++;
    if (rst) begin
      m_tx.delete();
      m_rx.delete();
      m_ph   = 0;
      m_last = 0;
    end else begin
      txn = m_tx.size();
      rxn = m_rx.size();
      if (m_ph == 1) void'(m_tx.pop_front());
      if (m_ph == 2) begin
        m_rx.push_back(chip_data);
        chip_data <= chip_data + 8'h1;
      end
      if (write && txn < 16) m_tx.push_back(din);
      if (read && rxn > 0) void'(m_rx.pop_front());
      if (m_ph == 0) begin
        tx_ok = (txn != 0) && !txe_n;
        rx_ok = (rxn != 16) && !rxf_n;
        if (tx_ok && (!rx_ok || m_last == 0)) begin
          m_ph   = 1;
          m_last = 1;
        end else if (rx_ok) begin
          m_ph   = 2;
          m_last = 0;
        end
      end else begin
        m_ph = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("wr_n", 32'(wr_n), 32'(m_ph != 1));
      chk("rd_n", 32'(rd_n), 32'(m_ph != 2));
      chk("tx_count", 32'(tx_count), 32'(m_tx.size()));
      chk("rx_count", 32'(rx_count), 32'(m_rx.size()));
      chk("full", 32'(full), 32'(m_tx.size() == 16));
      chk("avail", 32'(avail), 32'(m_rx.size() != 0));
      if (m_rx.size() != 0) chk("dout", 32'(dout), 32'(m_rx[0]));
      if (m_ph == 1) chk("usb_data", 32'(usb_data), 32'(m_tx[0]));
    end
    if (!wr_n) begin
      slog.push_back(8'h77);
      wlog.push_back(usb_data);
      wcyc.push_back(cyc);
    end
    if (!rd_n) slog.push_back(8'h72);
  end

  initial begin
    byte exp5 [5];
    int  w;
    exp5 = '{8'h77, 8'h72, 8'h77, 8'h72, 8'h77};
    rst = 1; rxf_n = 0; txe_n = 0;
    write = 0; read = 0; din = 0;
    @(posedge clk);
    chk_on = 1;
    tick(2);
    chk("t1_rd_n", 32'(rd_n), 1);
    chk("t1_wr_n", 32'(wr_n), 1);
    chk("t1_full", 32'(full), 0);
    chk("t1_avail", 32'(avail), 0);
    chk("t1_txc", 32'(tx_count), 0);
    chk("t1_rxc", 32'(rx_count), 0);
    rxf_n = 1; txe_n = 1;
    tick(1);
    rst = 0;
    tick(2);

    // TX burst
    txe_n = 0;
    clr_logs();
    for (int i = 0; i < 4; i++) begin
      write = 1;
      din   = 8'h11 + 8'(i);
      tick(1);
    end
    write = 0;
    tick(12);
    chk("t2_nwr", 32'(wlog.size()), 4);
    if (wlog.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("t2_byte", 32'(wlog[i]), 32'(8'h11 + 8'(i)));
      for (int i = 1; i < 4; i++) chk("t2_gap", 32'(wcyc[i] - wcyc[i-1]), 2);
    end
    chk("t2_txc", 32'(tx_count), 0);

    // TX full and drop
    txe_n = 1;
    for (int i = 0; i < 17; i++) begin
      write = 1;
      din   = 8'h30 + 8'(i);
      tick(1);
      if (i == 15) begin
        chk("t3_full16", 32'(full), 1);
        chk("t3_txc16", 32'(tx_count), 16);
      end
    end
    write = 0;
    chk("t3_txc17", 32'(tx_count), 16);
    clr_logs();
    txe_n = 0;
    tick(40);
    chk("t3_nwr", 32'(cnt(8'h77)), 16);
    if (wlog.size() >= 16) begin
      chk("t3_first", 32'(wlog[0]), 32'h30);
      chk("t3_last", 32'(wlog[15]), 32'h3F);
    end
    chk("t3_txc", 32'(tx_count), 0);

    // RX backpressure
    txe_n = 1;
    rxf_n = 0;
    clr_logs();
    tick(50);
    chk("t4_nrd", 32'(cnt(8'h72)), 16);
    chk("t4_rxc", 32'(rx_count), 16);
    chk("t4_avail", 32'(avail), 1);
    read = 1;
    tick(1);
    read = 0;
    tick(10);
    chk("t4_nrd2", 32'(cnt(8'h72)), 17);
    chk("t4_rxc2", 32'(rx_count), 16);
    rxf_n = 1;
    read  = 1;
    tick(16);
    read = 0;
    tick(1);
    chk("t4_drain", 32'(rx_count), 0);
    chk("t4_navail", 32'(avail), 0);

    // Arbitration after a fresh reset
    rst = 1;
    tick(1);
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      write = 1;
      din   = 8'h50 + 8'(i);
      tick(1);
    end
    write = 0;
    tick(1);
    clr_logs();
    txe_n = 0;
    rxf_n = 0;
    tick(12);
    chk("t5_len", 32'(slog.size() >= 5), 1);
    if (slog.size() >= 5)
      for (int i = 0; i < 5; i++) chk("t5_order", 32'(slog[i]), 32'(exp5[i]));
    chk("t5_nwr", 32'(cnt(8'h77)), 3);
    rxf_n = 1;
    tick(2);

    // Reset during WRITE
    txe_n = 1;
    for (int i = 0; i < 2; i++) begin
      write = 1;
      din   = 8'h60 + 8'(i);
      tick(1);
    end
    write = 0;
    txe_n = 0;
    w = 0;
    while (wr_n && w < 10) begin
      tick(1);
      w++;
    end
    chk("t6_wait", 32'(wr_n), 0);
    rst = 1;
    tick(1);
    chk("t6_wr_n", 32'(wr_n), 1);
    chk("t6_txc", 32'(tx_count), 0);
    rst = 0;
    clr_logs();
    tick(10);
    chk("t6_quiet", 32'(slog.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
